mem_arbiter: RTL and testbench

- Shares the single DDR/memory model port (28-bit line address, 256-bit line data, rw/valid/ready handshake) between the D-cache controller and the I-cache controller.
- Grants one requester at a time and holds the grant for the whole transaction.
- Multiplexes the granted request to memory and routes read data and ready back to the granted requester only.
- Round-robin fairness plus a watchdog that releases a hung transaction.

---
 rtl/mem_if_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared memory-port widths, arbiter state encoding and requester indices
package mem_if_pkg;
  localparam int MEM_ADDR_WIDTH = 28;
  localparam int MEM_LINE_WIDTH = 256;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_D = 2'b01;
  localparam logic [1:0] GNT_I = 2'b10;
  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between D-cache and I-cache, with a hang watchdog
module mem_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int BLOCK_SIZE     = MEM_LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [BLOCK_SIZE-1:0] d_wr,
  input  logic                  d_rw,
  input  logic                  d_valid,
  output logic [BLOCK_SIZE-1:0] d_rd,
  output logic                  d_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BLOCK_SIZE-1:0] i_wr,
  input  logic                  i_rw,
  input  logic                  i_valid,
  output logic [BLOCK_SIZE-1:0] i_rd,
  output logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wr,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rd,
  input  logic                  mem_ready,
  output logic [1:0]            grant,
  output logic                  timeout_err
);
  localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [1:0]    state, state_nx;
  logic          last, last_nx;
  logic [WW-1:0] wd_cnt;
  logic          gd, gi, x_valid, other_valid, wd_fire, timeout_set;
  assign gd          = state == GNT_D;
  assign gi          = state == GNT_I;
  assign x_valid     = gd ? d_valid : gi & i_valid;
  assign other_valid = gd ? i_valid : gi & d_valid;
  assign wd_fire     = TIMEOUT_CYCLES != 0 && wd_cnt == WW'(TIMEOUT_CYCLES);
  assign timeout_set = (gd | gi) && !mem_ready && x_valid && wd_fire;
  assign grant       = state;
  assign mem_addr    = gd ? d_addr : gi ? i_addr : '0;
  assign mem_wr      = gd ? d_wr : gi ? i_wr : '0;
  assign mem_rw      = gd ? d_rw : gi & i_rw;
  assign mem_valid   = x_valid;
  assign d_rd        = gd ? mem_rd : '0;
  assign i_rd        = gi ? mem_rd : '0;
  assign d_ready     = gd & mem_ready;
  assign i_ready     = gi & mem_ready;
  // next grant: tie in IDLE goes to the side not served last; completion hands over without a bubble
  always_comb begin
    state_nx = state;
    last_nx  = last;
    if (state == IDLE)
      state_nx = d_valid && (!i_valid || last == REQ_I) ? GNT_D : i_valid ? GNT_I : IDLE;
    else if (gd | gi) begin
      if (mem_ready) begin
        last_nx  = gd ? REQ_D : REQ_I;
        state_nx = other_valid ? (gd ? GNT_I : GNT_D) : IDLE;
      end else if (!x_valid)
        state_nx = IDLE;
      else if (wd_fire) begin
        last_nx  = gd ? REQ_D : REQ_I;
        state_nx = IDLE;
      end
    end else
      state_nx = IDLE;
  end
  // state, fairness history, watchdog counter (cleared on each new grant) and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= REQ_I;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nx;
      last   <= last_nx;
      wd_cnt <= (state == IDLE || state_nx != state) ? '0 : wd_cnt + WW'(1);
      if (timeout_set) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus hand sequences for watchdog and async reset
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 256;
  localparam logic [AW-1:0] D_ADDR = 28'h0000120;
  localparam logic [AW-1:0] I_ADDR = 28'h0000340;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] d_addr = D_ADDR, i_addr = I_ADDR, mem_addr;
  logic [BW-1:0] d_wr = {8{32'h11112222}}, i_wr = {8{32'h33334444}};
  logic [BW-1:0] mem_rd = {8{32'hDEADBEEF}}, d_rd, i_rd, mem_wr;
  logic d_rw = 1'b0, i_rw = 1'b0, d_valid = 1'b0, i_valid = 1'b0, mem_ready = 1'b0;
  logic d_ready, i_ready, mem_rw, mem_valid, timeout_err;
  logic [1:0] grant;
  int n_vec = 0, n_bad = 0;
  typedef struct packed {
    logic dv, iv, mr;
    logic [1:0] g;
    logic dr, ir, mv, err;
  } vec_t;
  vec_t v[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_addr(d_addr), .d_wr(d_wr), .d_rw(d_rw), .d_valid(d_valid), .d_rd(d_rd), .d_ready(d_ready),
    .i_addr(i_addr), .i_wr(i_wr), .i_rw(i_rw), .i_valid(i_valid), .i_rd(i_rd), .i_ready(i_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_ready(mem_ready), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic dv, iv, mr, input logic [1:0] g, input logic dr, ir, mv, err);
    v.push_back({dv, iv, mr, g, dr, ir, mv, err});
  endtask

  task automatic check(input string nm, input logic [1:0] g, input logic dr, ir, mv, err);
    logic [AW-1:0] ea;
    logic [BW-1:0] ew, edrd, eird;
    logic erw;
    logic ok;
    ea   = g == 2'b01 ? D_ADDR : g == 2'b10 ? I_ADDR : '0;
    ew   = g == 2'b01 ? d_wr : g == 2'b10 ? i_wr : '0;
    erw  = g == 2'b01 ? d_rw : g == 2'b10 ? i_rw : 1'b0;
    edrd = g == 2'b01 ? mem_rd : '0;
    eird = g == 2'b10 ? mem_rd : '0;
    ok = grant === g && d_ready === dr && i_ready === ir && mem_valid === mv &&
         timeout_err === err && mem_addr === ea && mem_wr === ew && mem_rw === erw &&
         d_rd === edrd && i_rd === eird;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got grant=%b d_ready=%b i_ready=%b mem_valid=%b err=%b addr=%h rw=%b wr_ok=%b d_rd_ok=%b i_rd_ok=%b; want grant=%b d_ready=%b i_ready=%b mem_valid=%b err=%b addr=%h rw=%b",
               nm, grant, d_ready, i_ready, mem_valid, timeout_err, mem_addr, mem_rw,
               mem_wr === ew, d_rd === edrd, i_rd === eird, g, dr, ir, mv, err, ea, erw);
    end
  endtask

  initial begin
    add(0,0,0, 2'b00, 0,0,0, 0);
    add(1,0,0, 2'b00, 0,0,0, 0);
    add(1,0,0, 2'b01, 0,0,1, 0);
    add(1,0,0, 2'b01, 0,0,1, 0);
    add(1,0,0, 2'b01, 0,0,1, 0);
    add(1,0,0, 2'b01, 0,0,1, 0);
    add(1,0,1, 2'b01, 1,0,1, 0);
    add(0,0,0, 2'b00, 0,0,0, 0);
    add(0,0,1, 2'b00, 0,0,0, 0);
    add(1,1,0, 2'b00, 0,0,0, 0);
    add(1,1,0, 2'b10, 0,0,1, 0);
    add(1,1,1, 2'b10, 0,1,1, 0);
    add(1,1,0, 2'b01, 0,0,1, 0);
    add(1,1,1, 2'b01, 1,0,1, 0);
    add(1,1,1, 2'b10, 0,1,1, 0);
    add(1,1,1, 2'b01, 1,0,1, 0);
    add(0,1,1, 2'b10, 0,1,1, 0);
    add(0,0,0, 2'b00, 0,0,0, 0);
    add(1,1,0, 2'b00, 0,0,0, 0);
    add(1,1,0, 2'b01, 0,0,1, 0);
    add(1,1,0, 2'b01, 0,0,1, 0);
    add(0,1,0, 2'b01, 0,0,0, 0);
    add(0,1,0, 2'b00, 0,0,0, 0);
    add(0,1,1, 2'b10, 0,1,1, 0);
    add(0,0,0, 2'b00, 0,0,0, 0);
    add(1,1,0, 2'b00, 0,0,0, 0);
    for (int k = 0; k < 9; k++) add(1,1,0, 2'b01, 0,0,1, 0);
    add(1,1,0, 2'b00, 0,0,0, 1);
    add(1,1,1, 2'b10, 0,1,1, 1);
    add(1,0,1, 2'b01, 1,0,1, 1);
    add(0,0,0, 2'b00, 0,0,0, 1);
    repeat (2) @(negedge clk);
    check("reset", 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < v.size(); k++) begin
      @(negedge clk);
      d_valid = v[k].dv;
      i_valid = v[k].iv;
      mem_ready = v[k].mr;
      #1 check($sformatf("vec%0d", k), v[k].g, v[k].dr, v[k].ir, v[k].mv, v[k].err);
    end
    @(negedge clk);
    d_valid = 1'b0;
    i_valid = 1'b1;
    i_rw = 1'b1;
    mem_ready = 1'b0;
    #1 check("wr_req", 2'b00, 0, 0, 0, 1);
    @(negedge clk);
    #1 check("wr_gnt", 2'b10, 0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d_valid = 1'b1;
    i_rw = 1'b0;
    #1 check("rst_idle", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #1 check("rst_tie", 2'b01, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
